// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared command encodings, state enum and decode helpers
//
// Purpose: one-hot command constants {MOVE_OUT,MOVE_IN,WAIT,JUMP,KICK,PUNCH},
//          the player state enum and command decode functions used by the
//          player core and the hit resolver.
// Ports:   none (package).

package fighter_pkg;

   localparam logic [5:0] CMD_IDLE     = 6'b000000;
   localparam logic [5:0] CMD_PUNCH    = 6'b000001;
   localparam logic [5:0] CMD_KICK     = 6'b000010;
   localparam logic [5:0] CMD_JUMP     = 6'b000100;
   localparam logic [5:0] CMD_WAIT     = 6'b001000;
   localparam logic [5:0] CMD_MOVE_IN  = 6'b010000;
   localparam logic [5:0] CMD_MOVE_OUT = 6'b100000;

   typedef enum logic [1:0] {
      ALIVE   = 2'd0,
      STUNNED = 2'd1,
      KO      = 2'd2
   } state_t;

   function automatic logic is_onehot6(input logic [5:0] cmd);
      return ($countones(cmd) == 1);
   endfunction

   // Anything that is not exactly one command bit collapses to IDLE.
   function automatic logic [5:0] decode_cmd(input logic [5:0] cmd);
      return is_onehot6(cmd) ? cmd : CMD_IDLE;
   endfunction

endpackage

// File: rtl/fighter_if.sv
// rtl/fighter_if.sv - command/status bundle between arena logic and one player core
//
// Purpose: groups the per-player command inputs and status outputs.
// Ports (master = arena side, slave = player core):
//   own_cmd, opp_cmd  6         one-hot commands (master -> slave)
//   opp_loc           LOC_W     opponent location (master -> slave)
//   opp_ko            1         opponent knocked out (master -> slave)
//   loc_out           LOC_W     player location (slave -> master)
//   health_out        HEALTH_W  player health (slave -> master)
//   ko, stunned       1         player state flags (slave -> master)
//   hit_pulse         1         one-cycle damage pulse (slave -> master)

interface fighter_if #(
   parameter int LOC_W    = 2,
   parameter int HEALTH_W = 3
);
   logic [5:0]          own_cmd;
   logic [5:0]          opp_cmd;
   logic [LOC_W-1:0]    opp_loc;
   logic                opp_ko;
   logic [LOC_W-1:0]    loc_out;
   logic [HEALTH_W-1:0] health_out;
   logic                ko;
   logic                stunned;
   logic                hit_pulse;

   modport master (
      output own_cmd, opp_cmd, opp_loc, opp_ko,
      input  loc_out, health_out, ko, stunned, hit_pulse
   );

   modport slave (
      input  own_cmd, opp_cmd, opp_loc, opp_ko,
      output loc_out, health_out, ko, stunned, hit_pulse
   );
endinterface

// File: rtl/fighter_hit_resolver.sv
// rtl/fighter_hit_resolver.sv - combinational resolution of one exchange of blows
//
// Purpose: given decoded own/opponent commands and the gap between players,
//          produce the damage taken and whether the player is pushed back.
// Ports:
//   own_cmd   in   6         decoded own command (IDLE if stunned/invalid)
//   opp_cmd   in   6         decoded opponent command
//   gap       in   GAP_W     own loc + opponent loc
//   dmg       out  HEALTH_W  damage taken this cycle
//   pushback  out  1         player is pushed one step toward the wall

module fighter_hit_resolver
   import fighter_pkg::*;
#(
   parameter int GAP_W     = 3,
   parameter int HEALTH_W  = 3,
   parameter int PUNCH_DMG = 2,
   parameter int KICK_DMG  = 1
) (
   input  logic [5:0]          own_cmd,
   input  logic [5:0]          opp_cmd,
   input  logic [GAP_W-1:0]    gap,
   output logic [HEALTH_W-1:0] dmg,
   output logic                pushback
);

   always_comb begin
      dmg      = '0;
      pushback = 1'b0;
      // A jumping player is immune to everything.
      if (own_cmd != CMD_JUMP) begin
         if (gap == '0) begin
            if (opp_cmd == CMD_PUNCH) begin
               if (own_cmd == CMD_PUNCH) pushback = 1'b1;
               else                      dmg      = HEALTH_W'(PUNCH_DMG);
            end else if (opp_cmd == CMD_KICK) begin
               // A punch at point-blank range beats a kick outright.
               if (own_cmd == CMD_KICK)       pushback = 1'b1;
               else if (own_cmd != CMD_PUNCH) dmg      = HEALTH_W'(KICK_DMG);
            end
         end else if (gap == GAP_W'(1)) begin
            // Only kicks reach one step away.
            if (opp_cmd == CMD_KICK) begin
               if (own_cmd == CMD_KICK) pushback = 1'b1;
               else                     dmg      = HEALTH_W'(KICK_DMG);
            end
         end
      end
   end

endmodule

// File: rtl/fighter_player_core.sv
// rtl/fighter_player_core.sv - per-player state engine (location, health, stun, KO)
//
// Purpose: each cycle resolves own command against the opponent's command and
//          the gap between them; updates location, saturating health with
//          regeneration, stun lockout, KO and a one-cycle hit pulse.
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   bus    fighter_if.slave: own_cmd, opp_cmd, opp_loc, opp_ko in;
//                            loc_out, health_out, ko, stunned, hit_pulse out

module fighter_player_core
   import fighter_pkg::*;
#(
   parameter int ARENA_LEN   = 3,
   parameter int LOC_W       = 2,
   parameter int HEALTH_W    = 3,
   parameter int MAX_HEALTH  = 7,
   parameter int INIT_HEALTH = 3,
   parameter int PUNCH_DMG   = 2,
   parameter int KICK_DMG    = 1,
   parameter int REGEN_WAIT  = 2,
   parameter int STUN_CYCLES = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   fighter_if.slave bus
);

   localparam int WAIT_W = $clog2(REGEN_WAIT + 1);
   localparam int STUN_W = (STUN_CYCLES > 0) ? $clog2(STUN_CYCLES + 1) : 1;
   localparam logic [LOC_W-1:0]  LOC_MAX = LOC_W'(ARENA_LEN - 1);
   localparam logic [HEALTH_W:0] MAX_H   = (HEALTH_W + 1)'(MAX_HEALTH);

   state_t              state, state_d;
   logic [LOC_W-1:0]    loc, loc_d;
   logic [HEALTH_W-1:0] health, health_d;
   logic [WAIT_W-1:0]   wait_cnt, wait_d;
   logic [STUN_W-1:0]   stun_cnt, stun_d;
   logic                hit_q, hit_d;

   logic                frozen;
   logic [5:0]          own_eff, opp_eff;
   logic [LOC_W:0]      gap;
   logic [HEALTH_W-1:0] dmg;
   logic                pushback;
   logic                regen;
   logic [WAIT_W-1:0]   wait_calc;
   logic [HEALTH_W:0]   health_sum, health_calc;
   logic [LOC_W-1:0]    loc_calc;
   logic [STUN_W-1:0]   stun_dec;

   assign frozen  = (state == KO) || bus.opp_ko;
   assign opp_eff = decode_cmd(bus.opp_cmd);
   assign own_eff = (state == STUNNED) ? CMD_IDLE : decode_cmd(bus.own_cmd);
   assign gap     = {1'b0, loc} + {1'b0, bus.opp_loc};

   fighter_hit_resolver #(
      .GAP_W     (LOC_W + 1),
      .HEALTH_W  (HEALTH_W),
      .PUNCH_DMG (PUNCH_DMG),
      .KICK_DMG  (KICK_DMG)
   ) u_resolver (
      .own_cmd  (own_eff),
      .opp_cmd  (opp_eff),
      .gap      (gap),
      .dmg      (dmg),
      .pushback (pushback)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ALIVE;
         loc      <= LOC_MAX;
         health   <= HEALTH_W'(INIT_HEALTH);
         wait_cnt <= '0;
         stun_cnt <= '0;
         hit_q    <= 1'b0;
      end else begin
         state    <= state_d;
         loc      <= loc_d;
         health   <= health_d;
         wait_cnt <= wait_d;
         stun_cnt <= stun_d;
         hit_q    <= hit_d;
      end
   end

   always_comb begin
      state_d  = state;
      loc_d    = loc;
      health_d = health;
      wait_d   = wait_cnt;
      stun_d   = stun_cnt;
      hit_d    = 1'b0;

      // Regen: damage in the same cycle cancels the wait streak, so regen
      // and damage never combine.
      regen     = 1'b0;
      wait_calc = '0;
      if ((dmg == '0) && (own_eff == CMD_WAIT)) begin
         if (wait_cnt == WAIT_W'(REGEN_WAIT - 1)) regen     = 1'b1;
         else                                     wait_calc = wait_cnt + WAIT_W'(1);
      end

      // One extra bit so neither the increment nor the subtraction can wrap.
      health_sum = {1'b0, health} + (HEALTH_W + 1)'(regen);
      if ({1'b0, dmg} >= health_sum) health_calc = '0;
      else                           health_calc = health_sum - {1'b0, dmg};
      if (health_calc > MAX_H) health_calc = MAX_H;

      // Pushback takes priority over the player's own movement.
      loc_calc = loc;
      if (pushback) begin
         if (loc < LOC_MAX) loc_calc = loc + LOC_W'(1);
      end else if (own_eff == CMD_MOVE_OUT) begin
         if (loc < LOC_MAX) loc_calc = loc + LOC_W'(1);
      end else if (own_eff == CMD_MOVE_IN) begin
         if (loc > '0) loc_calc = loc - LOC_W'(1);
      end

      stun_dec = stun_cnt - STUN_W'(1);

      if (!frozen) begin
         loc_d    = loc_calc;
         health_d = health_calc[HEALTH_W-1:0];
         wait_d   = wait_calc;
         hit_d    = (dmg != '0) && (health_calc != '0);
         if (health_calc == '0) begin
            state_d = KO;
            stun_d  = '0;
         end else if ((dmg != '0) && (STUN_CYCLES > 0)) begin
            state_d = STUNNED;
            stun_d  = STUN_W'(STUN_CYCLES);
         end else if (state == STUNNED) begin
            stun_d = stun_dec;
            if (stun_dec == '0) state_d = ALIVE;
         end
      end
   end

   assign bus.loc_out    = loc;
   assign bus.health_out = health;
   assign bus.ko         = (state == KO);
   assign bus.stunned    = (state == STUNNED);
   assign bus.hit_pulse  = hit_q;

endmodule

// File: tb/tb_fighter_player_core.sv
// tb/tb_fighter_player_core.sv - self-checking bench for fighter_player_core

module tb_fighter_player_core;

   localparam int M_PUNCH = 1;
   localparam int M_KICK  = 2;
   localparam int M_JUMP  = 4;
   localparam int M_WAIT  = 8;
   localparam int M_IN    = 16;
   localparam int M_OUT   = 32;
   localparam int M_MAXH  = 7;
   localparam int M_WALL  = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fighter_if #(.LOC_W(2), .HEALTH_W(3)) bus ();

   fighter_player_core #(
      .ARENA_LEN(3), .LOC_W(2), .HEALTH_W(3), .MAX_HEALTH(7), .INIT_HEALTH(3),
      .PUNCH_DMG(2), .KICK_DMG(1), .REGEN_WAIT(2), .STUN_CYCLES(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: integer game rules.
   int m_loc, m_health, m_stun, m_wait;
   bit m_ko, m_hit;

   function automatic bit onehot(int c);
      return c inside {1, 2, 4, 8, 16, 32};
   endfunction

   function void model_reset();
      m_loc = M_WALL; m_health = 3; m_stun = 0; m_wait = 0; m_ko = 0; m_hit = 0;
   endfunction

   function void model_step(int own, int opp, int oloc, bit oko);
      int o, p, d, h;
      bit push;
      if (m_ko || oko) begin
         m_hit = 0;
         return;
      end
      o = (onehot(own) && m_stun == 0) ? own : 0;
      p = onehot(opp) ? opp : 0;
      d = 0; push = 0;
      if (o != M_JUMP) begin
         if (m_loc + oloc == 0 && p == M_PUNCH) begin
            if (o == M_PUNCH) push = 1; else d = 2;
         end else if (m_loc + oloc == 0 && p == M_KICK) begin
            if (o == M_KICK) push = 1; else if (o != M_PUNCH) d = 1;
         end else if (m_loc + oloc == 1 && p == M_KICK) begin
            if (o == M_KICK) push = 1; else d = 1;
         end
      end
      h = m_health - d;
      if (d == 0 && o == M_WAIT) begin
         m_wait++;
         if (m_wait == 2) begin h++; m_wait = 0; end
      end else m_wait = 0;
      if (h < 0) h = 0;
      if (h > M_MAXH) h = M_MAXH;
      if (push || o == M_OUT) m_loc = (m_loc < M_WALL) ? m_loc + 1 : m_loc;
      else if (o == M_IN)     m_loc = (m_loc > 0) ? m_loc - 1 : 0;
      m_health = h;
      m_hit = (d > 0) && (h > 0);
      if (h == 0) begin m_ko = 1; m_stun = 0; end
      else if (d > 0) m_stun = 2;
      else if (m_stun > 0) m_stun--;
   endfunction

   function automatic logic [7:0] dut_vec();
      return {bus.loc_out, bus.health_out, bus.ko, bus.stunned, bus.hit_pulse};
   endfunction

   function automatic logic [7:0] model_vec();
      return {2'(m_loc), 3'(m_health), m_ko, (m_stun > 0), m_hit};
   endfunction

   task automatic drive(input int own, input int opp, input int oloc, input bit oko);
      @(negedge clk);
      bus.own_cmd = 6'(own);
      bus.opp_cmd = 6'(opp);
      bus.opp_loc = 2'(oloc);
      bus.opp_ko  = oko;
      @(posedge clk);
      #1;
      model_step(own, opp, oloc, oko);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.own_cmd = '0; bus.opp_cmd = '0; bus.opp_loc = 2'd2; bus.opp_ko = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      bus.own_cmd = '0; bus.opp_cmd = '0; bus.opp_loc = 2'd2; bus.opp_ko = 1'b0;
      rst_n = 1'b0;
      #12;
      n_checks++;
      if (dut_vec() !== 8'b10_011_000) begin
         n_fail++; $display("FAIL reset_state: got %b expected %b", dut_vec(), 8'b10_011_000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive(M_IN, 0, 2, 0);
      drive(M_IN, 0, 2, 0);
      drive(0, M_PUNCH, 0, 0);
      n_checks++;
      if (bus.health_out !== 3'd1) begin
         n_fail++; $display("FAIL reset_pre_health: got %0d expected 1", bus.health_out);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.loc_out, bus.health_out, bus.ko} !== {2'd2, 3'd3, 1'b0}) begin
         n_fail++; $display("FAIL reset_async: got loc %0d health %0d ko %b expected 2 3 0",
                            bus.loc_out, bus.health_out, bus.ko);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_punch_stun();
      do_reset();
      drive(M_IN, 0, 2, 0);
      drive(M_IN, 0, 2, 0);
      drive(0, M_PUNCH, 0, 0);
      n_checks++;
      if (dut_vec() !== 8'b00_001_011 || model_vec() !== 8'b00_001_011) begin
         n_fail++; $display("FAIL punch_hit: got %b model %b expected %b", dut_vec(), model_vec(), 8'b00_001_011);
      end
      for (int i = 0; i < 3; i++) begin
         drive(M_OUT, 0, 0, 0);
         n_checks++;
         if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL stun_lockout[%0d]: got %b expected %b", i, dut_vec(), model_vec());
         end
      end
      n_checks++;
      if (bus.loc_out !== 2'd1 || bus.stunned !== 1'b0) begin
         n_fail++; $display("FAIL stun_release: got loc %0d stunned %b expected 1 0", bus.loc_out, bus.stunned);
      end
   endtask

   task automatic test_pushback_jump();
      do_reset();
      drive(M_IN, 0, 2, 0);
      drive(M_IN, 0, 2, 0);
      drive(M_PUNCH, M_PUNCH, 0, 0);
      n_checks++;
      if ({bus.loc_out, bus.health_out, bus.hit_pulse} !== {2'd1, 3'd3, 1'b0}) begin
         n_fail++; $display("FAIL pushback: got loc %0d health %0d expected 1 3", bus.loc_out, bus.health_out);
      end
      drive(M_JUMP, M_KICK, 0, 0);
      n_checks++;
      if (dut_vec() !== model_vec() || bus.health_out !== 3'd3) begin
         n_fail++; $display("FAIL jump_immune: got %b expected %b", dut_vec(), model_vec());
      end
      drive(M_PUNCH, M_KICK, 0, 0);
      n_checks++;
      if (dut_vec() !== model_vec() || bus.health_out !== 3'd2) begin
         n_fail++; $display("FAIL kick_gap1: got %b expected %b", dut_vec(), model_vec());
      end
   endtask

   task automatic test_regen();
      do_reset();
      for (int i = 0; i < 6; i++) drive(M_WAIT, 0, 2, 0);
      n_checks++;
      if (bus.health_out !== 3'd6) begin
         n_fail++; $display("FAIL regen_to6: got %0d expected 6", bus.health_out);
      end
      for (int i = 0; i < 6; i++) begin
         drive(M_WAIT, 0, 2, 0);
         n_checks++;
         if (dut_vec() !== model_vec() || bus.health_out !== ((i == 0) ? 3'd6 : 3'd7)) begin
            n_fail++; $display("FAIL regen_cap[%0d]: got %b expected %b", i, dut_vec(), model_vec());
         end
      end
      do_reset();
      drive(M_WAIT, 0, 2, 0);
      drive(M_KICK, 0, 2, 0);
      drive(M_WAIT, 0, 2, 0);
      n_checks++;
      if (bus.health_out !== 3'd3) begin
         n_fail++; $display("FAIL regen_broken: got %0d expected 3", bus.health_out);
      end
      drive(M_WAIT, 0, 2, 0);
      n_checks++;
      if (bus.health_out !== 3'd4 || dut_vec() !== model_vec()) begin
         n_fail++; $display("FAIL regen_resume: got %0d expected 4", bus.health_out);
      end
   endtask

   task automatic test_ko_freeze();
      do_reset();
      drive(M_IN, 0, 2, 0);
      for (int k = 0; k < 3; k++) begin
         drive(0, M_KICK, 0, 0);
         if (k < 2) begin
            drive(0, 0, 0, 0);
            drive(0, 0, 0, 0);
         end
      end
      n_checks++;
      if ({bus.health_out, bus.ko, bus.hit_pulse} !== {3'd0, 1'b1, 1'b0} || dut_vec() !== model_vec()) begin
         n_fail++; $display("FAIL ko_entry: got %b expected %b", dut_vec(), model_vec());
      end
      drive(M_OUT, M_PUNCH, 0, 0);
      drive(M_WAIT, 0, 0, 0);
      drive(M_WAIT, 0, 0, 0);
      n_checks++;
      if (dut_vec() !== 8'b01_000_100) begin
         n_fail++; $display("FAIL ko_frozen: got %b expected %b", dut_vec(), 8'b01_000_100);
      end
      do_reset();
      drive(M_IN, M_KICK, 0, 1);
      drive(M_WAIT, M_PUNCH, 0, 1);
      drive(M_WAIT, M_PUNCH, 0, 1);
      n_checks++;
      if (dut_vec() !== 8'b10_011_000) begin
         n_fail++; $display("FAIL opp_ko_freeze: got %b expected %b", dut_vec(), 8'b10_011_000);
      end
   endtask

   task automatic test_limits_nonhot();
      do_reset();
      drive(M_OUT, 0, 2, 0);
      n_checks++;
      if (bus.loc_out !== 2'd2) begin
         n_fail++; $display("FAIL wall_limit: got %0d expected 2", bus.loc_out);
      end
      drive(M_IN, 0, 2, 0);
      drive(M_IN, 0, 2, 0);
      drive(M_IN, 0, 2, 0);
      n_checks++;
      if (bus.loc_out !== 2'd0) begin
         n_fail++; $display("FAIL centre_limit: got %0d expected 0", bus.loc_out);
      end
      drive(6'b110000, 0, 2, 0);
      n_checks++;
      if (bus.loc_out !== 2'd0 || dut_vec() !== model_vec()) begin
         n_fail++; $display("FAIL nonhot_move: got %b expected %b", dut_vec(), model_vec());
      end
      drive(6'b000011, M_PUNCH, 0, 0);
      n_checks++;
      if (bus.health_out !== 3'd1 || bus.loc_out !== 2'd0) begin
         n_fail++; $display("FAIL nonhot_block: got loc %0d health %0d expected 0 1", bus.loc_out, bus.health_out);
      end
   endtask

   task automatic test_random();
      int own, opp;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         own = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : (1 << $urandom_range(0, 5));
         opp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : (1 << $urandom_range(0, 5));
         drive(own, opp, int'($urandom_range(0, 2)), ($urandom_range(0, 15) == 0));
         n_checks++;
         if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL random[%0d] own %h opp %h: got %b expected %b",
                               i, own, opp, dut_vec(), model_vec());
         end
         if (m_ko && $urandom_range(0, 3) == 0) do_reset();
      end
   endtask

   initial begin
      test_reset();
      test_punch_stun();
      test_pushback_jump();
      test_regen();
      test_ko_freeze();
      test_limits_nonhot();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
